// File: rtl/egress_sched_defs.sv
// Shared definitions for the egress IPG scheduler: class encodings, counter width, class-pointer helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package egress_sched_defs;

  typedef enum logic [1:0] {
    CLS_RREQ    = 2'd0,
    CLS_WREQ    = 2'd1,
    CLS_RRESP   = 2'd2,
    CLS_INVALID = 2'd3
  } cls_e;

  // Number of real traffic classes per oport (rreq, wreq, rresp).
  localparam int NUM_CLS = 3;

  localparam int DROP_CNT_W = 16;

  // Next class in rreq -> wreq -> rresp -> rreq order.
  function automatic logic [1:0] cls_next(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

endpackage

// File: rtl/egress_class_fifo.sv
// Single-clock show-ahead FIFO holding one traffic class of one virtual oport.
// Latency: a write is visible at rd_data/empty on the next cycle; a read pops in the same cycle.
// Backpressure: full is taken from the pre-cycle count, so a full FIFO refuses a write even while being popped.
// Ports: clk, rst (sync, active-high), wr_en/wr_data, rd_en/rd_data (head entry), full, empty.
module egress_class_fifo #(
  parameter int DATA_WIDTH  = 64,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [QUEUE_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_wr;
  logic                  w_rd;

  assign full    = (r_count == CW'(QUEUE_DEPTH));
  assign empty   = (r_count == '0);
  assign rd_data = r_mem[r_rd_ptr];
  assign w_wr    = wr_en && !full;
  assign w_rd    = rd_en && !empty;

  // Pointers are AW bits wide, so they wrap modulo the (power-of-two) depth by themselves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset: clearing the pointers already discards the contents.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/egress_ipg_sched.sv
// Virtual-output scheduler: NUM_PORTS oports x 3 class FIFOs, one frame per tx_ready slot to the PHY IPG path.
// Latency: accept in cycle N is schedulable in N+1; a grant in cycle k shows tx_ipg_en=1 in k+1 (2 cycles minimum).
// Backpressure: in_ready drops combinationally when the target class FIFO is full; invalid frames are always taken and counted.
// Ports: clk/rst; in_valid/in_ready/in_data/in_src_port/in_type ingress; tx_ready in,
//        tx_ipg_en/tx_ipg_data/tx_ipg_port/tx_ipg_type registered egress; drop_count saturating drop counter.
module egress_ipg_sched
  import egress_sched_defs::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int NUM_PORTS   = 4,
  parameter int PORT_WIDTH  = $clog2(NUM_PORTS),
  parameter int QUEUE_DEPTH = 8,
  parameter int SCHED_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [PORT_WIDTH-1:0] in_src_port,
  input  logic [1:0]            in_type,
  input  logic                  tx_ready,
  output logic                  tx_ipg_en,
  output logic [DATA_WIDTH-1:0] tx_ipg_data,
  output logic [PORT_WIDTH-1:0] tx_ipg_port,
  output logic [1:0]            tx_ipg_type,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int                  NQ           = NUM_PORTS * NUM_CLS;
  localparam logic [PORT_WIDTH:0] LP_NUM_PORTS = (PORT_WIDTH + 1)'(NUM_PORTS);

  // Queue q = port*NUM_CLS + class.
  logic [NQ-1:0]         w_q_wr;
  logic [NQ-1:0]         w_q_rd;
  logic [NQ-1:0]         w_q_full;
  logic [NQ-1:0]         w_q_empty;
  logic [DATA_WIDTH-1:0] w_q_data [NQ];

  logic                  w_in_drop;
  logic                  w_tgt_full;
  logic [NUM_PORTS-1:0]  w_port_busy;
  logic                  w_any;
  logic [PORT_WIDTH-1:0] w_gnt_port;
  logic [NUM_CLS-1:0]    w_sel_empty;
  logic [1:0]            w_sel_ptr;
  logic                  w_cls_found;
  logic [1:0]            w_gnt_cls;
  logic                  w_grant;
  logic [DATA_WIDTH-1:0] w_gnt_data;

  logic [PORT_WIDTH-1:0] r_rr_ptr;
  logic [1:0]            r_cls_ptr [NUM_PORTS];
  logic                  r_tx_en;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [PORT_WIDTH-1:0] r_tx_port;
  logic [1:0]            r_tx_type;
  logic [DROP_CNT_W-1:0] r_drop;

  for (genvar gq = 0; gq < NQ; gq++) begin : g_q
    egress_class_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .QUEUE_DEPTH(QUEUE_DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (w_q_wr[gq]),
      .wr_data(in_data),
      .rd_en  (w_q_rd[gq]),
      .rd_data(w_q_data[gq]),
      .full   (w_q_full[gq]),
      .empty  (w_q_empty[gq])
    );
  end

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_busy
    assign w_port_busy[gp] = ~&w_q_empty[gp*NUM_CLS +: NUM_CLS];
  end

  // Ingress steering. Out-of-range ports and class 3 are swallowed as drops.
  always_comb begin
    w_in_drop  = (in_type == CLS_INVALID) || ({1'b0, in_src_port} >= LP_NUM_PORTS);
    w_q_wr     = '0;
    w_tgt_full = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int c = 0; c < NUM_CLS; c++) begin
        if (!w_in_drop && in_src_port == PORT_WIDTH'(p) && in_type == 2'(c)) begin
          w_tgt_full               = w_q_full[p*NUM_CLS+c];
          w_q_wr[p*NUM_CLS+c]      = in_valid;
        end
      end
    end
  end

  assign in_ready = w_in_drop || !w_tgt_full;

  // Rotate-priority oport search: ports at/after rr_ptr first, then the wrapped-around ones.
  always_comb begin
    w_any      = 1'b0;
    w_gnt_port = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!w_any && w_port_busy[p] && PORT_WIDTH'(p) >= r_rr_ptr) begin
        w_any      = 1'b1;
        w_gnt_port = PORT_WIDTH'(p);
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!w_any && w_port_busy[p] && PORT_WIDTH'(p) < r_rr_ptr) begin
        w_any      = 1'b1;
        w_gnt_port = PORT_WIDTH'(p);
      end
    end
  end

  // Class choice inside the granted oport.
  always_comb begin
    w_sel_empty = '1;
    w_sel_ptr   = 2'd0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (PORT_WIDTH'(p) == w_gnt_port) begin
        w_sel_empty = w_q_empty[p*NUM_CLS +: NUM_CLS];
        w_sel_ptr   = r_cls_ptr[p];
      end
    end
    w_cls_found = 1'b0;
    w_gnt_cls   = CLS_RREQ;
    if (SCHED_MODE == 0) begin
      if (!w_sel_empty[CLS_RRESP])     w_gnt_cls = CLS_RRESP;
      else if (!w_sel_empty[CLS_RREQ]) w_gnt_cls = CLS_RREQ;
      else                             w_gnt_cls = CLS_WREQ;
    end else begin
      // Same two-pass rotate as the oport search, starting at this port's class pointer.
      for (int c = 0; c < NUM_CLS; c++) begin
        if (!w_cls_found && !w_sel_empty[c] && 2'(c) >= w_sel_ptr) begin
          w_cls_found = 1'b1;
          w_gnt_cls   = 2'(c);
        end
      end
      for (int c = 0; c < NUM_CLS; c++) begin
        if (!w_cls_found && !w_sel_empty[c] && 2'(c) < w_sel_ptr) begin
          w_cls_found = 1'b1;
          w_gnt_cls   = 2'(c);
        end
      end
    end
  end

  assign w_grant = tx_ready && w_any;

  always_comb begin
    w_q_rd     = '0;
    w_gnt_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int c = 0; c < NUM_CLS; c++) begin
        if (PORT_WIDTH'(p) == w_gnt_port && 2'(c) == w_gnt_cls) begin
          w_q_rd[p*NUM_CLS+c] = w_grant;
          w_gnt_data          = w_q_data[p*NUM_CLS+c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      for (int p = 0; p < NUM_PORTS; p++) r_cls_ptr[p] <= 2'd0;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
      r_tx_port <= '0;
      r_tx_type <= 2'd0;
      r_drop    <= '0;
    end else begin
      r_tx_en <= w_grant;
      // Payload/port/type hold their last values through idle slots.
      if (w_grant) begin
        r_rr_ptr  <= (w_gnt_port == PORT_WIDTH'(NUM_PORTS - 1)) ? '0 : w_gnt_port + PORT_WIDTH'(1);
        r_tx_data <= w_gnt_data;
        r_tx_port <= w_gnt_port;
        r_tx_type <= w_gnt_cls;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (SCHED_MODE != 0 && w_grant && PORT_WIDTH'(p) == w_gnt_port)
          r_cls_ptr[p] <= cls_next(w_gnt_cls);
      end
      if (in_valid && w_in_drop && r_drop != '1)
        r_drop <= r_drop + DROP_CNT_W'(1);
    end
  end

  assign tx_ipg_en   = r_tx_en;
  assign tx_ipg_data = r_tx_data;
  assign tx_ipg_port = r_tx_port;
  assign tx_ipg_type = r_tx_type;
  assign drop_count  = r_drop;

endmodule

// File: tb/tb_egress_ipg_sched.sv
// Bench for egress_ipg_sched: two instances (strict-priority and class round-robin) share one stimulus stream;
// each has its own expected-emission queue, drained by a monitor sampling on the falling edge.
module tb_egress_ipg_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic [1:0]  in_src_port;
  logic [1:0]  in_type;
  logic        tx_ready;

  logic        rdy0, rdy1, en0, en1;
  logic [63:0] dat0, dat1;
  logic [1:0]  prt0, prt1, typ0, typ1;
  logic [15:0] drp0, drp1;

  always #5 clk = ~clk;

  egress_ipg_sched #(.SCHED_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_src_port(in_src_port), .in_type(in_type), .tx_ready(tx_ready), .tx_ipg_en(en0),
    .tx_ipg_data(dat0), .tx_ipg_port(prt0), .tx_ipg_type(typ0), .drop_count(drp0)
  );

  egress_ipg_sched #(.SCHED_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_src_port(in_src_port), .in_type(in_type), .tx_ready(tx_ready), .tx_ipg_en(en1),
    .tx_ipg_data(dat1), .tx_ipg_port(prt1), .tx_ipg_type(typ1), .drop_count(drp1)
  );

  typedef struct {
    logic [63:0] d;
    logic [1:0]  p;
    logic [1:0]  t;
    int          c;   // required emission cycle, -1 = any
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic mon(input int d, input logic en, input logic [63:0] data,
                     input logic [1:0] port, input logic [1:0] typ);
    exp_t e;
    if (en !== 1'b1) return;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_chk++;
      $display("FAIL unexpected_emit dut%0d: got data %h port %0d type %0d at cycle %0d, required no emission",
               d, data, port, typ, cyc);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      check($sformatf("emit_data dut%0d", d), data, e.d);
      check($sformatf("emit_port dut%0d", d), 64'(port), 64'(e.p));
      check($sformatf("emit_type dut%0d", d), 64'(typ), 64'(e.t));
      if (e.c >= 0) check($sformatf("emit_cycle dut%0d", d), 64'(cyc), 64'(e.c));
    end
  endtask

  always @(negedge clk) begin
    mon(0, en0, dat0, prt0, typ0);
    mon(1, en1, dat1, prt1, typ1);
  end

  task automatic push0(input logic [63:0] d, input logic [1:0] p, input logic [1:0] t, input int c);
    exp_t e;
    e.d = d; e.p = p; e.t = t; e.c = c;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [63:0] d, input logic [1:0] p, input logic [1:0] t, input int c);
    exp_t e;
    e.d = d; e.p = p; e.t = t; e.c = c;
    q1.push_back(e);
  endtask

  task automatic push_both(input logic [63:0] d, input logic [1:0] p, input logic [1:0] t, input int c);
    push0(d, p, t, c);
    push1(d, p, t, c);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One accepted frame per call; in_ready must be high on both instances.
  task automatic send(input logic [1:0] port, input logic [1:0] typ, input logic [63:0] data);
    in_valid = 1'b1; in_src_port = port; in_type = typ; in_data = data;
    #1;
    check("in_ready dut0", 64'(rdy0), 64'd1);
    check("in_ready dut1", 64'(rdy1), 64'd1);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    int          t0;
    logic [63:0] dv;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_src_port = '0; in_type = '0; tx_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    #1;

    // Reset state.
    check("rst in_ready dut0", 64'(rdy0), 64'd1);
    check("rst in_ready dut1", 64'(rdy1), 64'd1);
    check("rst tx_ipg_en dut0", 64'(en0), 64'd0);
    check("rst tx_ipg_en dut1", 64'(en1), 64'd0);
    check("rst tx_ipg_data dut0", dat0, 64'd0);
    check("rst tx_ipg_port dut0", 64'(prt0), 64'd0);
    check("rst tx_ipg_type dut0", 64'(typ0), 64'd0);
    check("rst drop_count dut0", 64'(drp0), 64'd0);
    check("rst drop_count dut1", 64'(drp1), 64'd0);

    // Single frame: accepted in cycle 10, emitted in cycle 12.
    tx_ready = 1'b1;
    while (cyc < 10) tick(1);
    push_both(64'h123456781234561a, 2'd1, 2'd2, cyc + 2);
    send(2'd1, 2'd2, 64'h123456781234561a);
    tick(4);

    // Oport fairness: arrivals in reverse order, emissions 0,1,2,3 back to back, twice.
    do_reset();
    tx_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int p = 3; p >= 0; p--) begin
        dv = 64'hF000_0000_0000_0000 + 64'(r * 16 + p);
        send(2'(p), 2'd0, dv);
      end
      t0 = cyc;
      for (int p = 0; p < 4; p++) begin
        dv = 64'hF000_0000_0000_0000 + 64'(r * 16 + p);
        push_both(dv, 2'(p), 2'd0, t0 + 1 + p);
      end
      tx_ready = 1'b1;
      tick(6);
      tx_ready = 1'b0;
    end

    // Class policy on port 2: A=wreq, B=rreq, C=rresp.
    do_reset();
    send(2'd2, 2'd1, 64'hAAAA_AAAA_AAAA_AAAA);
    send(2'd2, 2'd0, 64'hBBBB_BBBB_BBBB_BBBB);
    send(2'd2, 2'd2, 64'hCCCC_CCCC_CCCC_CCCC);
    t0 = cyc;
    push0(64'hCCCC_CCCC_CCCC_CCCC, 2'd2, 2'd2, t0 + 1);
    push0(64'hBBBB_BBBB_BBBB_BBBB, 2'd2, 2'd0, t0 + 2);
    push0(64'hAAAA_AAAA_AAAA_AAAA, 2'd2, 2'd1, t0 + 3);
    push1(64'hBBBB_BBBB_BBBB_BBBB, 2'd2, 2'd0, t0 + 1);
    push1(64'hAAAA_AAAA_AAAA_AAAA, 2'd2, 2'd1, t0 + 2);
    push1(64'hCCCC_CCCC_CCCC_CCCC, 2'd2, 2'd2, t0 + 3);
    tx_ready = 1'b1;
    tick(5);

    // Full queue: 8 wreq to port 0, 9th refused, then 8 emitted in order.
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(2'd0, 2'd1, 64'h5100 + 64'(i));
    in_valid = 1'b1; in_src_port = 2'd0; in_type = 2'd1; in_data = 64'hDEAD_DEAD_DEAD_DEAD;
    #1;
    check("full in_ready dut0", 64'(rdy0), 64'd0);
    check("full in_ready dut1", 64'(rdy1), 64'd0);
    tick(1);
    in_valid = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 8; i++) push_both(64'h5100 + 64'(i), 2'd0, 2'd1, t0 + 1 + i);
    tx_ready = 1'b1;
    tick(11);

    // Invalid class: dropped and counted, never emitted.
    for (int i = 0; i < 3; i++) send(2'(i), 2'd3, 64'h0BAD + 64'(i));
    tick(3);
    check("drop_count dut0", 64'(drp0), 64'd3);
    check("drop_count dut1", 64'(drp1), 64'd3);

    // Back-pressure: tx_ready 1,0,1 gives tx_ipg_en 1,0,1 with data held in the gap.
    tx_ready = 1'b0;
    send(2'd1, 2'd0, 64'hD0D0_0000_0000_0001);
    send(2'd1, 2'd0, 64'hE0E0_0000_0000_0002);
    t0 = cyc;
    push_both(64'hD0D0_0000_0000_0001, 2'd1, 2'd0, t0 + 1);
    push_both(64'hE0E0_0000_0000_0002, 2'd1, 2'd0, t0 + 3);
    tx_ready = 1'b1;
    tick(1);
    tx_ready = 1'b0;
    tick(1);
    check("gap tx_ipg_en dut0", 64'(en0), 64'd0);
    check("gap tx_ipg_en dut1", 64'(en1), 64'd0);
    check("gap data hold dut0", dat0, 64'hD0D0_0000_0000_0001);
    check("gap data hold dut1", dat1, 64'hD0D0_0000_0000_0001);
    tx_ready = 1'b1;
    tick(1);
    tx_ready = 1'b0;
    tick(3);

    // Mid-operation reset with 5 frames queued: nothing may come out afterwards.
    send(2'd0, 2'd0, 64'h7700);
    send(2'd1, 2'd1, 64'h7701);
    send(2'd2, 2'd2, 64'h7702);
    send(2'd3, 2'd0, 64'h7703);
    send(2'd0, 2'd1, 64'h7704);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    check("post-rst in_ready dut0", 64'(rdy0), 64'd1);
    check("post-rst in_ready dut1", 64'(rdy1), 64'd1);
    check("post-rst tx_ipg_en dut0", 64'(en0), 64'd0);
    check("post-rst drop_count dut0", 64'(drp0), 64'd0);
    check("post-rst drop_count dut1", 64'(drp1), 64'd0);
    tx_ready = 1'b1;
    tick(10);

    check("leftover expected dut0", 64'(q0.size()), 64'd0);
    check("leftover expected dut1", 64'(q1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/egress_ipg_sched.md
# egress_ipg_sched

Per-port virtual-output scheduler feeding the IPG injection path of the 10G switch egress PHY. Frames arriving from the switch fabric are sorted into NUM_PORTS virtual oports, one per ingress port, each holding three class queues: rreq, wreq and rresp. Whenever the PHY offers an IPG slot, exactly one 64-bit frame is selected: round-robin across oports, then by class policy within the granted oport. The selected frame drives tx_ipg_en/tx_ipg_data of the egress PHY wrapper.

## Interface
- DATA_WIDTH, 64, frame width in bits.
- NUM_PORTS, 4, number of virtual oports (≥2).
- PORT_WIDTH, $clog2(NUM_PORTS), width of the port index.
- QUEUE_DEPTH, 8, entries per class queue; must be a power of 2 and ≥2.
- SCHED_MODE, 0, intra-port policy: 0 = strict priority rresp > rreq > wreq; 1 = round-robin over the three classes.

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  frame offered.
- in_ready  out  1  target queue can accept.
- in_data  in  DATA_WIDTH  frame payload.
- in_src_port  in  PORT_WIDTH  ingress port, which selects the oport.
- in_type  in  2  class: 0 rreq, 1 wreq, 2 rresp, 3 invalid.
- tx_ready  in  1  PHY IPG slot available this cycle.
- tx_ipg_en  out  1  tx_ipg_data valid for one cycle.
- tx_ipg_data  out  DATA_WIDTH  frame to the PHY.
- tx_ipg_port  out  PORT_WIDTH  oport of the emitted frame.
- tx_ipg_type  out  2  class of the emitted frame.
- drop_count  out  16  saturating count of dropped frames.

## Operation
- Accept rules:
  - An accept happens when in_valid && in_ready.
  - in_ready is combinational: for in_type 0–2 it is !full of queue [in_src_port][in_type]; for in_type 3 it is 1.
  - in_src_port ≥ NUM_PORTS is treated as invalid.
  - An invalid frame is accepted, discarded, and increments drop_count (saturates at 16'hFFFF).
- Full is evaluated on the pre-cycle count. A full queue refuses a write even if it is popped in the same cycle.
- Scheduling, in a cycle with tx_ready=1:
  - Oport search starts at rr_ptr, takes the first oport p with any non-empty queue, and wraps modulo NUM_PORTS.
  - Class selection within p:
    - SCHED_MODE=0: strict rresp, then rreq, then wreq.
    - SCHED_MODE=1: search starts at cls_ptr[p] in order rreq→wreq→rresp, with wrap; afterwards cls_ptr[p] = granted class + 1 mod 3.
  - The chosen queue is popped. rr_ptr becomes (p+1) mod NUM_PORTS. The frame, p and class are registered to the outputs.
- No grant occurs if tx_ready=0 or all queues are empty. Pointers are then unchanged.
- Reset: all queues are emptied and their contents discarded, including mid-operation. All outputs and state clear as follows:
  - rr_ptr=0 and every cls_ptr=0.
  - tx_ipg_en=0, tx_ipg_data=0, tx_ipg_port=0, tx_ipg_type=0.
  - drop_count=0.
  - in_ready is 1 after reset because the queues are empty.

## Timing
- Accept latency: a frame accepted in cycle N is visible to the scheduler in N+1.
- Emit latency: a grant in cycle k gives tx_ipg_en=1 in k+1, with data, port and type valid. Minimum accept-to-emit latency is 2 cycles.
- After a cycle with no grant, tx_ipg_en=0 for one cycle. tx_ipg_data, tx_ipg_port and tx_ipg_type hold their last values.
- Throughput: at most one frame per cycle in total, and at most one accept per cycle.
- Occupancy per queue is 0..QUEUE_DEPTH. A count of width $clog2(QUEUE_DEPTH)+1 distinguishes full from empty. Read/write pointers wrap modulo QUEUE_DEPTH.
- Simultaneous accept and pop on the same non-full queue is legal and leaves the count unchanged.

## Structure
- Shared header egress_sched_defs holds:
  - class encodings CLS_RREQ=0, CLS_WREQ=1, CLS_RRESP=2, CLS_INVALID=3;
  - the drop counter width (16).
- Sub-module egress_class_fifo: synchronous single-clock FIFO parametrised on DATA_WIDTH and QUEUE_DEPTH, with ports wr_en, rd_en, full, empty and a show-ahead read. It is instantiated NUM_PORTS×3 times via generate.
- Arbitration is a combinational rotate-priority search plus registered pointers inside egress_ipg_sched.
- egress_ipg_sched outputs connect directly to the egress wrapper's tx_ipg_en/tx_ipg_data.

## Test plan
- Single frame path: after reset, one frame with in_data=64'h123456781234561a, port 1, type 2, accepted at cycle 10 while tx_ready is held at 1 → tx_ipg_en=1 only at cycle 12, with data 64'h123456781234561a, port 1, type 2.
- Oport fairness: one rreq queued in each of ports 0–3 before tx_ready rises → emitted in port order 0,1,2,3 on 4 consecutive cycles. Refill and repeat with rr_ptr=0 → the same order again.
- Class policy within one port: port 2 holds one wreq (A), one rreq (B) and one rresp (C).
  - SCHED_MODE=0 → emitted C, B, A.
  - SCHED_MODE=1 → emitted B, A, C.
- Full queue and drops:
  - Push 8 wreq frames to port 0 with tx_ready=0 → in_ready=0 on the 9th; the 9th is not stored. Then tx_ready=1 → exactly 8 frames emitted, in FIFO order.
  - Push 3 frames with in_type=3 → drop_count=3 and nothing emitted.
- Back-pressure and mid-operation reset:
  - Toggle tx_ready 1,0,1 with 2 frames queued → tx_ipg_en pattern 1,0,1, with data held during the 0 cycle.
  - Assert rst with 5 frames queued → next cycle in_ready=1, tx_ipg_en=0, drop_count=0, and nothing is emitted afterwards.
